// File: rtl/apu_region_table_pkg.sv
// Shared encodings for the APU region table: permission codes, config field
// codes and attribute bit positions.
package apu_region_table_pkg;

    localparam int unsigned DEFAULT_CMP_W = 28;

    localparam logic [1:0] PERM_OPEN = 2'b00;
    localparam logic [1:0] PERM_RP   = 2'b01;
    localparam logic [1:0] PERM_WP   = 2'b10;
    localparam logic [1:0] PERM_RWP  = 2'b11;

    typedef enum logic [1:0] {
        CFG_FIELD_BASE  = 2'd0,
        CFG_FIELD_LIMIT = 2'd1,
        CFG_FIELD_ATTR  = 2'd2,
        CFG_FIELD_CTRL  = 2'd3
    } cfg_field_e;

    localparam int unsigned ATTR_RP = 0;
    localparam int unsigned ATTR_WP = 1;
    localparam int unsigned ATTR_EN = 2;
    localparam int unsigned ATTR_W  = 3;

    localparam logic [3:0] CFG_LOCK_IDX = 4'd15;

    function automatic logic [1:0] attr_perm(input logic [ATTR_W-1:0] attr);
        return {attr[ATTR_WP], attr[ATTR_RP]};
    endfunction

endpackage

// File: rtl/apu_region_match.sv
// Single-region address compare: hit when enabled and base <= addr < limit.
// An inverted window (base >= limit) can never satisfy both bounds.
module apu_region_match
    import apu_region_table_pkg::*;
#(
    parameter int unsigned CMP_W = DEFAULT_CMP_W
) (
    input  logic [CMP_W-1:0] addr_i,
    input  logic [CMP_W-1:0] base_i,
    input  logic [CMP_W-1:0] limit_i,
    input  logic             en_i,
    output logic             match_o
);

    assign match_o = en_i && (base_i <= addr_i) && (addr_i < limit_i);

endmodule

// File: rtl/apu_region_table.sv
// Programmable multi-region access-permission unit with violation log.
// Optional configuration lock enabled by defining APU_CFG_LOCK_EN.
module apu_region_table
    import apu_region_table_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CMP_W       = DEFAULT_CMP_W,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned RGN_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_perm,
    output logic              resp_grant,
    output logic              resp_hit,
    output logic [RGN_W-1:0]  resp_region,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [1:0]        cfg_field,
    input  logic [CMP_W-1:0]  cfg_wdata,
    input  logic              viol_clr,
    output logic              viol_valid,
    output logic [ADDR_W-1:0] viol_addr,
    output logic              viol_write,
    output logic [CNT_W-1:0]  viol_cnt
);

    logic [CMP_W-1:0]  base_q  [NUM_REGIONS];
    logic [CMP_W-1:0]  limit_q [NUM_REGIONS];
    logic [ATTR_W-1:0] attr_q  [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] match;
    logic                   hit_d;
    logic [RGN_W-1:0]       region_d;
    logic [1:0]             perm_d;
    logic                   grant_d;

    logic              resp_valid_q, resp_grant_q, resp_hit_q, resp_write_q;
    logic [1:0]        resp_perm_q;
    logic [RGN_W-1:0]  resp_region_q;
    logic [ADDR_W-1:0] resp_addr_q;

    logic              viol_valid_q, viol_write_q;
    logic [ADDR_W-1:0] viol_addr_q;
    logic [CNT_W-1:0]  viol_cnt_q;

    logic req_fire, resp_fire, viol_evt, cfg_ok;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
        apu_region_match #(.CMP_W(CMP_W)) u_match (
            .addr_i  (req_addr[CMP_W-1:0]),
            .base_i  (base_q[g]),
            .limit_i (limit_q[g]),
            .en_i    (attr_q[g][ATTR_EN]),
            .match_o (match[g])
        );
    end

    // Lowest matching index wins.
    always_comb begin
        hit_d    = 1'b0;
        region_d = '0;
        perm_d   = PERM_OPEN;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (match[i] && !hit_d) begin
                hit_d    = 1'b1;
                region_d = RGN_W'(i);
                perm_d   = attr_perm(attr_q[i]);
            end
        end
        grant_d = !(req_write ? perm_d[1] : perm_d[0]);
    end

    // Held low during reset so every output reads 0 while ARESETN is asserted.
    assign req_ready = ARESETN && (!resp_valid_q || resp_ready);
    assign req_fire  = req_valid && req_ready;
    assign resp_fire = resp_valid_q && resp_ready;
    assign viol_evt  = resp_fire && !resp_grant_q;

`ifdef APU_CFG_LOCK_EN
    logic lock_q;
    logic lock_set;

    assign lock_set = cfg_we && (cfg_idx == CFG_LOCK_IDX) && (cfg_field == CFG_FIELD_CTRL);
    assign cfg_ok   = cfg_we && !lock_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            lock_q <= 1'b0;
        end else if (lock_set) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign cfg_ok = cfg_we;
`endif

    // Out-of-range indices match no entry and fall through silently.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                base_q[i]  <= '0;
                limit_q[i] <= '0;
                attr_q[i]  <= '0;
            end
        end else if (cfg_ok) begin
            for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                if (cfg_idx == 4'(i)) begin
                    case (cfg_field)
                        CFG_FIELD_BASE:  base_q[i]  <= cfg_wdata;
                        CFG_FIELD_LIMIT: limit_q[i] <= cfg_wdata;
                        CFG_FIELD_ATTR:  attr_q[i]  <= cfg_wdata[ATTR_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            resp_valid_q  <= 1'b0;
            resp_perm_q   <= '0;
            resp_grant_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_region_q <= '0;
            resp_addr_q   <= '0;
            resp_write_q  <= 1'b0;
        end else if (req_fire) begin
            resp_valid_q  <= 1'b1;
            resp_perm_q   <= perm_d;
            resp_grant_q  <= grant_d;
            resp_hit_q    <= hit_d;
            resp_region_q <= region_d;
            resp_addr_q   <= req_addr;
            resp_write_q  <= req_write;
        end else if (resp_ready) begin
            resp_valid_q  <= 1'b0;
        end
    end

    // A coinciding clear restarts the log with the new violation.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            viol_valid_q <= 1'b0;
            viol_addr_q  <= '0;
            viol_write_q <= 1'b0;
            viol_cnt_q   <= '0;
        end else if (viol_evt) begin
            if (viol_clr) begin
                viol_cnt_q <= CNT_W'(1);
            end else if (viol_cnt_q != '1) begin
                viol_cnt_q <= viol_cnt_q + CNT_W'(1);
            end
            if (!viol_valid_q || viol_clr) begin
                viol_valid_q <= 1'b1;
                viol_addr_q  <= resp_addr_q;
                viol_write_q <= resp_write_q;
            end
        end else if (viol_clr) begin
            viol_cnt_q   <= '0;
            viol_valid_q <= 1'b0;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_perm   = resp_perm_q;
    assign resp_grant  = resp_grant_q;
    assign resp_hit    = resp_hit_q;
    assign resp_region = resp_region_q;
    assign viol_valid  = viol_valid_q;
    assign viol_addr   = viol_addr_q;
    assign viol_write  = viol_write_q;
    assign viol_cnt    = viol_cnt_q;

endmodule

// File: tb/tb_apu_region_table.sv
// Scoreboard bench for apu_region_table with a rule-level reference model.
// Lock scenario runs only when APU_CFG_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_apu_region_table;

    localparam int unsigned NR      = 4;
    localparam int unsigned TCNT_W  = 4;
    localparam int unsigned CNT_MAX = (1 << TCNT_W) - 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_grant, resp_hit;
    logic [1:0]  resp_perm, resp_region;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [1:0]  cfg_field = '0;
    logic [27:0] cfg_wdata = '0;
    logic        viol_clr = 1'b0, viol_valid, viol_write;
    logic [31:0] viol_addr;
    logic [TCNT_W-1:0] viol_cnt;

    apu_region_table #(.NUM_REGIONS(NR), .ADDR_W(32), .CMP_W(28), .CNT_W(TCNT_W)) dut (
        .ACLK(clk), .ARESETN(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_perm(resp_perm),
        .resp_grant(resp_grant), .resp_hit(resp_hit), .resp_region(resp_region),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
        .viol_clr(viol_clr), .viol_valid(viol_valid), .viol_addr(viol_addr),
        .viol_write(viol_write), .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  perm;
        logic        grant;
        logic        hit;
        logic [1:0]  region;
        logic [31:0] addr;
        logic        write;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int n_acc = 0, n_rx = 0;

    // Reference state
    int unsigned m_base[NR], m_limit[NR], m_attr[NR];
    bit          m_lock = 0;
    bit          pend = 0;
    exp_t        pend_item;
    int unsigned vcnt = 0;
    bit          vvalid = 0, vwrite = 0;
    logic [31:0] vaddr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic [31:0] a, input logic w);
        exp_t e;
        int unsigned lo;
        lo = a & 32'h0FFF_FFFF;
        e.perm = 2'b00; e.grant = 1'b1; e.hit = 1'b0; e.region = 2'd0;
        e.addr = a; e.write = w;
        for (int i = 0; i < NR; i++) begin
            if (((m_attr[i] >> 2) & 1) == 1 && m_base[i] <= lo && lo < m_limit[i]) begin
                e.hit    = 1'b1;
                e.region = 2'(i);
                e.perm   = 2'(m_attr[i] & 3);
                e.grant  = w ? ((m_attr[i] & 2) == 0) : ((m_attr[i] & 1) == 0);
                return e;
            end
        end
        return e;
    endfunction

    // Issue side: tracks accepted requests, the table and the violation log.
    always @(posedge clk) begin
        bit rdy, consumed;
        if (!rstn) begin
            for (int i = 0; i < NR; i++) begin m_base[i] = 0; m_limit[i] = 0; m_attr[i] = 0; end
            m_lock = 0;
            n_acc -= exp_q.size();
            exp_q.delete();
            pend = 0; vcnt = 0; vvalid = 0; vwrite = 0; vaddr = '0;
        end else begin
            rdy = !pend || resp_ready;
            consumed = pend && resp_ready;
            if (consumed) pend = 0;
            if (consumed && !pend_item.grant) begin
                vcnt = viol_clr ? 1 : (vcnt == CNT_MAX ? CNT_MAX : vcnt + 1);
                if (!vvalid || viol_clr) begin
                    vvalid = 1; vaddr = pend_item.addr; vwrite = pend_item.write;
                end
            end else if (viol_clr) begin
                vcnt = 0; vvalid = 0;
            end
            if (req_valid && rdy) begin
                pend_item = predict(req_addr, req_write);
                pend = 1;
                exp_q.push_back(pend_item);
                n_acc++;
            end
            if (cfg_we && !m_lock && cfg_idx < NR) begin
                case (cfg_field)
                    2'd0: m_base[cfg_idx]  = cfg_wdata;
                    2'd1: m_limit[cfg_idx] = cfg_wdata;
                    2'd2: m_attr[cfg_idx]  = cfg_wdata & 7;
                    default: ;
                endcase
            end
`ifdef APU_CFG_LOCK_EN
            if (cfg_we && cfg_idx == 4'd15 && cfg_field == 2'd3) m_lock = 1;
`endif
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        chk("req_ready", req_ready, rstn && (exp_q.size() == 0 || resp_ready));
        chk("resp_valid", resp_valid, exp_q.size() != 0);
        if (resp_valid && exp_q.size() != 0) begin
            chk("resp_perm",   resp_perm,   exp_q[0].perm);
            chk("resp_grant",  resp_grant,  exp_q[0].grant);
            chk("resp_hit",    resp_hit,    exp_q[0].hit);
            chk("resp_region", resp_region, exp_q[0].region);
            if (resp_ready) begin
                void'(exp_q.pop_front());
                n_rx++;
            end
        end
        chk("viol_cnt",   viol_cnt,   vcnt);
        chk("viol_valid", viol_valid, vvalid);
        if (vvalid) begin
            chk("viol_addr",  viol_addr,  vaddr);
            chk("viol_write", viol_write, vwrite);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cfg(input int idx, input int field, input int data);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_field = 2'(field); cfg_wdata = 28'(data);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic w);
        bit acc;
        int n;
        req_valid = 1'b1; req_addr = a; req_write = w;
        n = 0;
        do begin
            @(negedge clk); acc = req_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string nm, input logic [1:0] p, input logic g, input logic h, input logic [1:0] r);
        @(negedge clk);
        chk({nm, "_valid"},  resp_valid,  1'b1);
        chk({nm, "_perm"},   resp_perm,   p);
        chk({nm, "_grant"},  resp_grant,  g);
        chk({nm, "_hit"},    resp_hit,    h);
        chk({nm, "_region"}, resp_region, r);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
    endtask

    initial begin
        repeat (2) step();
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready",  req_ready, 0);
        chk("rst_perm",       resp_perm, 0);
        chk("rst_grant",      resp_grant, 0);
        chk("rst_hit",        resp_hit, 0);
        chk("rst_viol",       {viol_valid, viol_write, viol_addr, viol_cnt}, 0);
        step();
        rstn = 1'b1;
        resp_ready = 1'b1;
        step();

        send(32'h0000_1000, 1'b0);
        expect_resp("open", 2'b00, 1'b1, 1'b0, 2'd0);

        cfg(0, 0, 'h100); cfg(0, 1, 'h200); cfg(0, 2, 3'b101);
        send(32'h0000_0150, 1'b0);
        expect_resp("r0_rd", 2'b01, 1'b0, 1'b1, 2'd0);
        step();
        @(negedge clk);
        chk("r0_viol_cnt",  viol_cnt, 1);
        chk("r0_viol_addr", viol_addr, 32'h150);
        send(32'h0000_0150, 1'b1);
        expect_resp("r0_wr", 2'b01, 1'b1, 1'b1, 2'd0);

        cfg(1, 0, 'h180); cfg(1, 1, 'h300); cfg(1, 2, 3'b110);
        send(32'h0000_01A0, 1'b1);
        expect_resp("ovl_r0", 2'b01, 1'b1, 1'b1, 2'd0);
        send(32'hF000_0250, 1'b1);
        expect_resp("ovl_r1", 2'b10, 1'b0, 1'b1, 2'd1);
        step();

        // Backpressure with a request held valid
        resp_ready = 1'b0;
        send(32'h0000_0120, 1'b1);
        fork
            send(32'h0000_0250, 1'b0);
            begin
                repeat (3) begin @(negedge clk); chk("stall_ready", req_ready, 0); end
                @(posedge clk); #1 resp_ready = 1'b1;
            end
        join
        send(32'h0000_0050, 1'b0);
        send(32'h0000_0190, 1'b1);
        step();

        // Saturate the counter, then clear together with a fresh violation
        for (int i = 0; i < 20; i++) send(32'h0000_0150, 1'b0);
        step();
        @(negedge clk);
        chk("sat_cnt", viol_cnt, CNT_MAX);
        chk("sat_addr", viol_addr, 32'h150);
        step();
        send(32'h0000_01C0, 1'b0);
        viol_clr = 1'b1;
        step();
        viol_clr = 1'b0;
        @(negedge clk);
        chk("clr_viol_cnt",   viol_cnt, 1);
        chk("clr_viol_addr",  viol_addr, 32'h1C0);
        chk("clr_viol_valid", viol_valid, 1);
        step();
        viol_clr = 1'b1; step(); viol_clr = 1'b0;
        @(negedge clk);
        chk("clr_only", {viol_valid, viol_cnt}, 0);
        step();

        // Reset with a result pending
        resp_ready = 1'b0;
        send(32'h0000_0150, 1'b0);
        do_reset();
        @(negedge clk);
        chk("midrst_valid", resp_valid, 0);
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_addr   = {$urandom_range(0, 15), 28'($urandom_range(0, 'h3FF))};
            req_write  = $urandom_range(0, 1);
            resp_ready = ($urandom_range(0, 3) != 0);
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_idx    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            cfg_field  = 2'($urandom_range(0, 3));
            cfg_wdata  = 28'($urandom_range(0, 'h3FF));
            viol_clr   = ($urandom_range(0, 31) == 0);
            step();
        end
        req_valid = 1'b0; cfg_we = 1'b0; viol_clr = 1'b0; resp_ready = 1'b1;
        repeat (4) step();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_count", n_rx, n_acc);

`ifdef APU_CFG_LOCK_EN
        do_reset();
        step();
        cfg(0, 0, 'h100); cfg(0, 1, 'h200); cfg(0, 2, 3'b101);
        cfg(15, 3, 0);
        cfg(0, 1, 'h400);
        send(32'h0000_0300, 1'b0);
        expect_resp("lock_hold", 2'b00, 1'b1, 1'b0, 2'd0);
        step();
        do_reset();
        step();
        cfg(0, 0, 'h100); cfg(0, 1, 'h400); cfg(0, 2, 3'b101);
        send(32'h0000_0300, 1'b0);
        expect_resp("unlock", 2'b01, 1'b0, 1'b1, 2'd0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
